// File: rtl/siso_branch_metric_top.sv
// Branch-metric front end of the max-log-MAP SISO decoder: pairs systematic and
// parity beats with the a-priori LLR and emits the two saturated initial branch metrics.
module siso_branch_metric_top #(
    parameter int W              = 16,
    parameter int BLKLEN_W       = 13,
    parameter int BLKLEN_DEFAULT = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W-1:0]        in,
    input  logic                valid_in,
    input  logic                valid_apriori,
    input  logic [W-1:0]        apriori,
    input  logic [BLKLEN_W-1:0] blklen,
    output logic [W-1:0]        init_branch1_t,
    output logic [W-1:0]        init_branch2_t,
    output logic                valid_out
);

    localparam int XW = W + 2;
    localparam logic [BLKLEN_W-1:0] DEF_LEN = BLKLEN_W'(BLKLEN_DEFAULT);

    typedef enum logic {SYS = 1'b0, PAR = 1'b1} phase_t;

    phase_t              phase, phase_nxt;
    logic                sys_load, par_beat;
    logic [W-1:0]        sys_reg, apr_reg, apr_eff;
    logic                apr_pending;
    logic [BLKLEN_W-1:0] step_cnt, blk_len, blk_len_sel;
    logic                blk_wrap;
    logic [XW-1:0]       sys_x, apr_x, par_x, sum_p, sum_m;

    function automatic logic [W-1:0] sat(input logic [XW-1:0] v);
        // The top three bits agree exactly when the value fits in W bits.
        if (v[XW-1:W-1] == '0 || v[XW-1:W-1] == '1)
            sat = v[W-1:0];
        else if (v[XW-1])
            sat = {1'b1, {(W-1){1'b0}}};
        else
            sat = {1'b0, {(W-1){1'b1}}};
    endfunction

    // Phase FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase <= SYS;
        else     phase <= phase_nxt;
    end

    // Phase FSM: next state
    always_comb begin
        phase_nxt = phase;
        if (valid_in) begin
            case (phase)
                SYS:     phase_nxt = PAR;
                PAR:     phase_nxt = SYS;
                default: phase_nxt = SYS;
            endcase
        end
        if (par_beat && blk_wrap) phase_nxt = SYS;
    end

    // Phase FSM: outputs
    always_comb begin
        sys_load = valid_in && (phase == SYS);
        par_beat = valid_in && (phase == PAR);
    end

    // An undriven or zero blklen falls through to the default length.
    always_comb begin
        if (|blklen) blk_len_sel = blklen;
        else         blk_len_sel = DEF_LEN;
    end

    assign blk_wrap = (step_cnt == blk_len - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
            blk_len  <= DEF_LEN;
        end else begin
            if (sys_load && step_cnt == '0) blk_len <= blk_len_sel;
            if (par_beat) step_cnt <= blk_wrap ? '0 : step_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sys_reg <= '0;
        else if (sys_load) sys_reg <= in;
    end

    // The PAR beat always consumes (and so clears) any pending a-priori value,
    // including one arriving on that same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apr_reg     <= '0;
            apr_pending <= 1'b0;
        end else begin
            if (valid_apriori) apr_reg <= apriori;
            if (par_beat)           apr_pending <= 1'b0;
            else if (valid_apriori) apr_pending <= 1'b1;
        end
    end

    always_comb begin
        if (valid_apriori)    apr_eff = apriori;
        else if (apr_pending) apr_eff = apr_reg;
        else                  apr_eff = '0;
    end

    assign sys_x = {{2{sys_reg[W-1]}}, sys_reg};
    assign apr_x = {{2{apr_eff[W-1]}}, apr_eff};
    assign par_x = {{2{in[W-1]}}, in};
    assign sum_p = sys_x + apr_x + par_x;
    assign sum_m = sys_x + apr_x - par_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_branch1_t <= '0;
            init_branch2_t <= '0;
            valid_out      <= 1'b0;
        end else begin
            valid_out <= par_beat;
            if (par_beat) begin
                init_branch1_t <= sat(sum_p);
                init_branch2_t <= sat(sum_m);
            end
        end
    end

endmodule

// File: tb/tb_siso_branch_metric_top.sv
// Directed and randomized checks of siso_branch_metric_top against an
// arithmetic per-step reference model.
module tb_siso_branch_metric_top;

    localparam int W = 16;
    localparam int BW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_d, apriori;
    logic          valid_in, valid_apriori;
    logic [BW-1:0] blklen;
    logic [W-1:0]  b1, b2;
    logic          valid_out;

    int n_assert = 0;
    int n_fail   = 0;

    siso_branch_metric_top #(.W(W), .BLKLEN_W(BW), .BLKLEN_DEFAULT(512)) dut (
        .clk(clk), .rst(rst), .in(in_d), .valid_in(valid_in),
        .valid_apriori(valid_apriori), .apriori(apriori), .blklen(blklen),
        .init_branch1_t(b1), .init_branch2_t(b2), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic beat(input int d, input bit vi, input bit va, input int a);
        @(negedge clk);
        in_d = d[W-1:0];
        valid_in = vi;
        valid_apriori = va;
        apriori = a[W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        beat(0, 1'b0, 1'b0, 0);
    endtask

    task automatic check_step(input string tag, input int s, input int a, input int p);
        check({tag, "_vo"}, {31'd0, valid_out}, 1);
        check({tag, "_b1"}, $signed(b1), sat(s + a + p));
        check({tag, "_b2"}, $signed(b2), sat(s + a - p));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_in = 1'b0;
        valid_apriori = 1'b0;
        @(posedge clk);
        #1;
        check("rst_vo", {31'd0, valid_out}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int s, p, a, pulses;
        rst = 1'b1; in_d = '0; apriori = '0; valid_in = 1'b0;
        valid_apriori = 1'b0; blklen = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_b1", $signed(b1), 0);
        check("reset_b2", $signed(b2), 0);
        check("reset_vo", {31'd0, valid_out}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic step, a-priori coincident with parity
        beat(100, 1, 0, 0);
        check("basic_sys_vo", {31'd0, valid_out}, 0);
        beat(20, 1, 1, -30);
        check_step("basic", 100, -30, 20);
        idle();
        check("basic_strobe", {31'd0, valid_out}, 0);
        check("basic_hold", $signed(b1), 90);

        // Saturation both directions
        beat(30000, 1, 0, 0);
        beat(5000, 1, 1, 10000);
        check_step("sat_pos", 30000, 10000, 5000);
        beat(-30000, 1, 0, 0);
        beat(5000, 1, 1, -10000);
        check_step("sat_neg", -30000, -10000, 5000);

        // Mid-step gaps, no a-priori
        beat(-7, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("gap_vo", {31'd0, valid_out}, 0);
        end
        beat(4, 1, 0, 0);
        check_step("gap", -7, 0, 4);

        // A-priori arriving early with the systematic beat is held for parity
        beat(50, 1, 1, 7);
        idle();
        beat(-10, 1, 0, 0);
        check_step("early_apr", 50, 7, -10);
        beat(1, 1, 0, 0);
        beat(1, 1, 0, 0);
        check_step("apr_cleared", 1, 0, 1);

        // Reset mid-step discards the pending systematic beat
        beat(99, 1, 0, 0);
        do_reset();
        beat(1, 1, 0, 0);
        check("midrst_sys_vo", {31'd0, valid_out}, 0);
        beat(2, 1, 1, 3);
        check_step("midrst", 1, 3, 2);

        // Short blocks: a-priori only on the first step
        do_reset();
        blklen = 13'd4;
        for (int k = 0; k < 10; k++) begin
            s = rnd16();
            p = rnd16();
            a = (k == 0) ? rnd16() : 0;
            beat(s, 1, 0, 0);
            check("blk_sys_vo", {31'd0, valid_out}, 0);
            beat(p, 1, k == 0, a);
            check_step("blk4", s, a, p);
        end

        // Full default-length block streamed back to back
        do_reset();
        blklen = '0;
        pulses = 0;
        for (int k = 0; k < 512; k++) begin
            s = rnd16();
            p = rnd16();
            a = rnd16();
            beat(s, 1, 0, 0);
            check("stream_sys_vo", {31'd0, valid_out}, 0);
            beat(p, 1, 1, a);
            if (valid_out === 1'b1) pulses++;
            check_step("stream", s, a, p);
        end
        idle();
        check("stream_tail_vo", {31'd0, valid_out}, 0);
        check("stream_pulses", pulses, 512);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/siso_branch_metric_top.md
Name: siso_branch_metric_top

Overview:
- Front end of the SISO (max-log-MAP) turbo-decoder datapath.
- Takes an interleaved LLR stream in which each trellis step is a systematic beat followed by a parity beat, plus an a-priori LLR stream.
- Per trellis step it produces the two distinct initial branch metrics consumed by the alpha/beta recursion units.
- Outputs are registered and qualified by a one-cycle valid_out strobe per step.

Parameters:
- W, 16, width of the in, apriori and output metric words (signed two's complement).
- BLKLEN_W, 13, width of the blklen port.
- BLKLEN_DEFAULT, 512, block length in trellis steps used when blklen == 0.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  W  signed channel LLR; beats alternate systematic, parity, systematic, parity, ...
- valid_in  input  1  qualifies in; each high cycle is one beat.
- valid_apriori  input  1  qualifies apriori.
- apriori  input  W  signed a-priori LLR for the current trellis step.
- blklen  input  BLKLEN_W  block length in trellis steps; 0 (or undriven/unknown) selects BLKLEN_DEFAULT.
- init_branch1_t  output  W  signed metric, equal to sat(sys + apriori + par).
- init_branch2_t  output  W  signed metric, equal to sat(sys + apriori - par).
- valid_out  output  1  one-cycle strobe marking the output metrics valid.

Behaviour:
- Reset (async, rst=1):
  - Outputs: init_branch1_t=0, init_branch2_t=0, valid_out=0.
  - Internal: phase=SYS, sys_reg=0, apr_reg=0, step_cnt=0.
  - Release takes effect on the next clock edge.
- Phase FSM, two states SYS and PAR, advancing only on valid_in=1 cycles:
  - SYS with valid_in: capture in into sys_reg; go to PAR.
  - PAR with valid_in: in is the parity LLR. Compute metrics from sys_reg, effective apriori and in. Register the metrics and assert valid_out on the following cycle. Go to SYS.
  - valid_in=0: state and registers hold. Gaps of any length are allowed between beats, including mid-step.
- A-priori handling:
  - When valid_apriori=1, capture apriori into apr_reg and set apr_pending.
  - Effective apriori on the PAR beat is apriori itself if valid_apriori=1 that cycle (normal alignment: coincident with the parity beat), else apr_reg if apr_pending, else 0.
  - apr_pending clears after the PAR beat consumes it, so a step with no a-priori uses 0 (first half-iteration).
- Arithmetic:
  - Sign-extend operands to W+2 bits and form sys+apr+par and sys+apr-par.
  - Saturate each result to [-2^(W-1), 2^(W-1)-1]. No wrap-around.
- Latency and output timing:
  - Metrics appear on the cycle after the PAR-beat edge.
  - valid_out is high for exactly one cycle per completed step, so the maximum output rate is one step every 2 cycles.
  - Metric outputs hold their last value when valid_out=0.
- Block counting:
  - step_cnt increments on each PAR beat.
  - On reaching L-1 it wraps to 0, where L = blklen if nonzero else BLKLEN_DEFAULT.
  - At wrap: phase forced to SYS and apr_pending cleared, so every block starts aligned.
  - blklen is sampled at the start of each block, i.e. when step_cnt=0 on the SYS beat.
- Simultaneous events: rst dominates everything; a valid_apriori coincident with a SYS beat is stored for the upcoming PAR beat.
- Reset mid-step: a partial step is discarded, no valid_out is produced, and the next valid_in beat is treated as systematic.

Test Plan:
- Reset then single step sys=100, par=20 with coincident apriori=-30 -> one valid_out pulse 1 cycle after the parity beat; branch1=90, branch2=50.
- Saturation: sys=30000, apr=10000, par=5000 -> branch1=32767, branch2=32767; sys=-30000, apr=-10000, par=5000 -> branch1=-32768, branch2=-32768.
- Continuous 512-step stream, valid_in held high with apriori on odd beats, checked against a golden reference model -> exactly 512 valid_out pulses, each on every 2nd cycle, all metrics match.
- Gaps: insert 3 idle cycles between sys and par beats, then sys=-7, par=4, no apriori -> branch1=-3, branch2=-11; valid_out only after the parity beat.
- Mid-step reset: sys beat sent, rst asserted, then sys=1, par=2, apr=3 -> no output for the aborted step; branch1=6, branch2=2.
- blklen=4: ten steps sent with valid_apriori only on the first step -> step_cnt wraps after 4 steps; a-priori is consumed only by the first step, later steps use 0.
